// File: rtl/fetch_pkg.sv
// Shared types and opcode constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT_LO   = 2'd0,
    BOOT_HI   = 2'd1,
    FETCH_OP  = 2'd2,
    FETCH_IMM = 2'd3
  } fetch_state_e;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_IADD = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_LDM  = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_JMP  = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_CALL = 5'b10001;
  localparam logic [OPC_W-1:0] OPC_RET  = 5'b10010;

  localparam logic [OPC_W-1:0] IMM_MASK_DEF  = 5'b11111;
  localparam logic [OPC_W-1:0] IMM_MATCH_DEF = OPC_LDM;

  function automatic logic is_two_word(input logic [OPC_W-1:0] opcode);
    return (opcode & IMM_MASK_DEF) == IMM_MATCH_DEF;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline slot: flush clears it, load captures new contents, otherwise it holds.
import fetch_pkg::*;

module if_id_reg #(
  parameter int INST_W = 16,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic              d_valid,
  input  logic [INST_W-1:0] d_instr,
  input  logic [INST_W-1:0] d_imm,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [PC_W-1:0]   d_pc_next,
  output logic              q_valid,
  output logic [INST_W-1:0] q_instr,
  output logic [INST_W-1:0] q_imm,
  output logic [PC_W-1:0]   q_pc,
  output logic [PC_W-1:0]   q_pc_next
);

  logic              valid_q, valid_d;
  logic [INST_W-1:0] instr_q, instr_d;
  logic [INST_W-1:0] imm_q, imm_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   pc_next_q, pc_next_d;

  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    pc_next_d = pc_next_q;
    if (flush) begin
      valid_d   = 1'b0;
      instr_d   = '0;
      imm_d     = '0;
      pc_d      = '0;
      pc_next_d = '0;
    end else if (load) begin
      valid_d   = d_valid;
      instr_d   = d_instr;
      imm_d     = d_imm;
      pc_d      = d_pc;
      pc_next_d = d_pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      pc_next_q <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
    end
  end

  assign q_valid   = valid_q;
  assign q_instr   = instr_q;
  assign q_imm     = imm_q;
  assign q_pc      = pc_q;
  assign q_pc_next = pc_next_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, one/two-word assembly FSM and IF/ID slot.
// Optional boot-vector PC load after reset is enabled with `define FETCH_BOOT_VECTOR_EN.
import fetch_pkg::*;

module fetch_unit #(
  parameter int                   INST_W    = 16,
  parameter int                   PC_W      = 32,
  parameter int                   OPCODE_W  = 5,
  parameter logic [OPCODE_W-1:0]  IMM_MASK  = IMM_MASK_DEF,
  parameter logic [OPCODE_W-1:0]  IMM_MATCH = IMM_MATCH_DEF,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [PC_W-1:0]      BOOT_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              if_valid,
  output logic [INST_W-1:0] if_instr,
  output logic [INST_W-1:0] if_imm,
  output logic [PC_W-1:0]   if_pc,
  output logic [PC_W-1:0]   if_pc_next
);

`ifdef FETCH_BOOT_VECTOR_EN
  localparam bit           BOOT_EN = 1'b1;
  localparam fetch_state_e ST_RST  = BOOT_LO;
`else
  localparam bit           BOOT_EN = 1'b0;
  localparam fetch_state_e ST_RST  = FETCH_OP;
`endif
  localparam logic [PC_W-1:0] PC_RST = BOOT_EN ? BOOT_ADDR : RESET_PC;
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] hold_instr_q, hold_instr_d;
  logic [PC_W-1:0]   hold_pc_q, hold_pc_d;

  logic              slot_load, slot_flush, slot_valid;
  logic [INST_W-1:0] slot_instr, slot_imm;
  logic [PC_W-1:0]   slot_pc, slot_pc_next;
  logic [PC_W-1:0]   pc_inc;
  logic              two_word;

  assign pc_inc   = pc_q + PC_ONE;
  assign two_word = (imem_rdata[INST_W-1 -: OPCODE_W] & IMM_MASK) == IMM_MATCH;

`ifdef FETCH_BOOT_VECTOR_EN
  logic [2*INST_W-1:0] boot_vec;
  // During boot the hold register temporarily carries the low boot word.
  assign boot_vec = {imem_rdata, hold_instr_q};
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    slot_load    = 1'b0;
    slot_flush   = 1'b0;
    slot_valid   = 1'b0;
    slot_instr   = '0;
    slot_imm     = '0;
    slot_pc      = '0;
    slot_pc_next = '0;
    case (state_q)
`ifdef FETCH_BOOT_VECTOR_EN
      BOOT_LO: begin
        hold_instr_d = imem_rdata;
        pc_d         = pc_inc;
        state_d      = BOOT_HI;
      end
      BOOT_HI: begin
        pc_d         = boot_vec[PC_W-1:0];
        hold_instr_d = '0;
        state_d      = FETCH_OP;
      end
`endif
      FETCH_OP, FETCH_IMM: begin
        if (redirect) begin
          pc_d         = redirect_pc;
          state_d      = FETCH_OP;
          hold_instr_d = '0;
          hold_pc_d    = '0;
          slot_flush   = 1'b1;
        end else if (!stall) begin
          pc_d = pc_inc;
          if (state_q == FETCH_IMM) begin
            slot_load    = 1'b1;
            slot_valid   = 1'b1;
            slot_instr   = hold_instr_q;
            slot_imm     = imem_rdata;
            slot_pc      = hold_pc_q;
            slot_pc_next = pc_inc;
            state_d      = FETCH_OP;
          end else if (two_word) begin
            // Opcode half of a two-word instruction: park it and emit a bubble.
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_q;
            slot_flush   = 1'b1;
            state_d      = FETCH_IMM;
          end else begin
            slot_load    = 1'b1;
            slot_valid   = 1'b1;
            slot_instr   = imem_rdata;
            slot_pc      = pc_q;
            slot_pc_next = pc_inc;
          end
        end
      end
      default: state_d = FETCH_OP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RST;
      pc_q         <= PC_RST;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  assign imem_addr = pc_q;

  if_id_reg #(
    .INST_W (INST_W),
    .PC_W   (PC_W)
  ) u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (slot_load),
    .flush     (slot_flush),
    .d_valid   (slot_valid),
    .d_instr   (slot_instr),
    .d_imm     (slot_imm),
    .d_pc      (slot_pc),
    .d_pc_next (slot_pc_next),
    .q_valid   (if_valid),
    .q_instr   (if_instr),
    .q_imm     (if_imm),
    .q_pc      (if_pc),
    .q_pc_next (if_pc_next)
  );

endmodule
